// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore sequencer, ALU decode,
// NZCV flag register and per-instruction condition latch.
module multicycle_controller #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state;
    state_t     next;
    logic [3:0] flags;
    logic       condreg;
    logic       condex;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign rd    = Instr[3:0];
    assign cmd   = funct[4:1];

    logic [1:0] dp_ctl;
    logic       dp_bad;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic       fetch;
    logic       addsub;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   next = funct[5] ? EXECI : EXECR;
                    2'b01:   next = MEMADR;
                    2'b10:   next = BRANCH;
                    default: next = FETCH;
                endcase
            end
            MEMADR:   next = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  next = MEMWB;
            EXECR:    next = ALUWB;
            EXECI:    next = ALUWB;
            default:  next = FETCH;
        endcase
    end

    // Unrecognised commands fall back to add and never write back.
    always_comb begin
        dp_ctl = 2'b00;
        dp_bad = 1'b0;
        unique case (1'b1)
            (cmd == 4'b0100): dp_ctl = 2'b00;
            (cmd == 4'b0010): dp_ctl = 2'b01;
            (cmd == 4'b0000): dp_ctl = 2'b10;
            (cmd == 4'b1100): dp_ctl = 2'b11;
            default:          dp_bad = 1'b1;
        endcase
    end

    always_comb begin
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        aluop     = 1'b0;
        fetch     = 1'b0;
        case (state)
            FETCH: begin
                fetch     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            EXECR:    aluop = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                aluop   = 1'b1;
            end
            ALUWB:    regw = ~dp_bad;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: begin
                fetch     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
        endcase
    end

    assign ALUControl = aluop ? dp_ctl : 2'b00;
    assign ImmSrc     = op;
    assign RegSrc     = {op == 2'b01, op == 2'b10};

    assign IRWrite  = fetch & ~reset;
    assign RegWrite = regw & condreg & ~reset;
    assign MemWrite = memw & condreg & ~reset;
    assign PCWrite  = (fetch | ((branch | (regw & (rd == 4'hF))) & condreg))
                    & ~reset;

    always_comb begin
        condex = 1'b0;
        case (cond)
            4'h0: condex = flags[2];
            4'h1: condex = ~flags[2];
            4'h2: condex = flags[1];
            4'h3: condex = ~flags[1];
            4'h4: condex = flags[3];
            4'h5: condex = ~flags[3];
            4'h6: condex = flags[0];
            4'h7: condex = ~flags[0];
            4'h8: condex = flags[1] & ~flags[2];
            4'h9: condex = ~flags[1] | flags[2];
            4'hA: condex = flags[3] == flags[0];
            4'hB: condex = flags[3] != flags[0];
            4'hC: condex = ~flags[2] & (flags[3] == flags[0]);
            4'hD: condex = flags[2] | (flags[3] != flags[0]);
            4'hE: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign addsub = ~dp_ctl[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            condreg <= 1'b0;
        end else if (state == DECODE) begin
            condreg <= condex;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= FLAGS_RST;
        end else if ((state == EXECR || state == EXECI) && condreg && funct[0]) begin
            flags[3:2] <= ALUFlags[3:2];
            if (addsub) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign Flags = flags;
    assign State = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised and directed instruction streams checked cycle by cycle
// against an instruction-level model of the controller.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
    logic [3:0]  Flags, State;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] mflags;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .Flags(Flags), .State(State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] observed();
        return {8'h0, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc,
                ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, Flags, State};
    endfunction

    // Expected outputs in a given step of an instruction.
    function automatic logic [31:0] expected(input int s, input logic [31:0] ins,
                                             input logic ok, input logic [3:0] f);
        logic [1:0] op;
        logic [3:0] cmd;
        logic [1:0] dpc, srcb, aluc, res;
        logic bad, pcw, irw, mw, adr, srca, rw, br;
        op = ins[27:26];
        cmd = ins[24:21];
        bad = 1'b0;
        case (cmd)
            4'b0100: dpc = 2'd0;
            4'b0010: dpc = 2'd1;
            4'b0000: dpc = 2'd2;
            4'b1100: dpc = 2'd3;
            default: begin dpc = 2'd0; bad = 1'b1; end
        endcase
        {pcw, irw, mw, adr, srca, rw, br} = '0;
        srcb = 0; aluc = 0; res = 0;
        case (s)
            0: begin srca = 1; srcb = 2; res = 2; irw = 1; pcw = 1; end
            1: begin srca = 1; srcb = 2; res = 2; end
            2: srcb = 1;
            3: adr = 1;
            4: begin res = 1; rw = 1; end
            5: begin adr = 1; mw = ok; end
            6: aluc = dpc;
            7: begin srcb = 1; aluc = dpc; end
            8: rw = !bad;
            default: begin srcb = 1; res = 2; br = 1; end
        endcase
        if ((br || (rw && ins[15:12] == 4'hF)) && ok) pcw = 1;
        return {8'h0, pcw, irw, rw && ok, mw, adr, op == 2'b01, op == 2'b10,
                op, srca, srcb, aluc, res, f, s[3:0]};
    endfunction

    // Entered and left one time unit after a rising edge.
    task automatic run_instr(input string tag, input logic [31:0] ins,
                             input logic [3:0] af, input int abort_at);
        int seq[$];
        logic ok;
        logic [3:0] cmd;
        Instr = ins[31:12];
        ALUFlags = af;
        ok = passes(ins[31:28], mflags);
        cmd = ins[24:21];
        seq = '{0, 1};
        case (ins[27:26])
            2'b00: begin seq.push_back(ins[25] ? 7 : 6); seq.push_back(8); end
            2'b01: if (ins[20]) begin seq.push_back(3 - 1); seq.push_back(3);
                                      seq.push_back(4); end
                   else begin seq.push_back(2); seq.push_back(5); end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        foreach (seq[i]) begin
            @(negedge clk);
            check(tag, observed(), expected(seq[i], ins, ok, mflags));
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort", {RegWrite, MemWrite, PCWrite, IRWrite, State, Flags},
                      {4'b0000, 4'd0, 4'b0000});
                mflags = 4'b0000;
                @(posedge clk);
                #1 reset = 1'b0;
                @(posedge clk);
                #1 check("restart", {28'h0, State}, 32'd1);
                return;
            end
            @(posedge clk);
            #1;
            if ((seq[i] == 6 || seq[i] == 7) && ok && ins[20])
                mflags = {af[3:2], (cmd == 4'b0100 || cmd == 4'b0010)
                                   ? af[1:0] : mflags[1:0]};
        end
    endtask

    function automatic logic [3:0] legal_cmd();
        logic [3:0] t [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
        return t[$urandom_range(0, 3)];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic s;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
        if (w[27:26] == 2'b00) begin
            s = w[20];
            if (s || $urandom_range(0, 3) != 0) w[24:21] = legal_cmd();
        end
        return w;
    endfunction

    initial begin
        reset = 1'b1;
        Instr = '0;
        ALUFlags = '0;
        mflags = 4'b0000;
        #12;
        check("reset", observed(), {8'h0, 5'b00000, 4'b0000, 1'b1, 2'b10,
                                    2'b00, 2'b10, 4'b0000, 4'd0});
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr("add", 32'hE0821003, 4'b1111, -1);
        run_instr("ldr", 32'hE5904004, 4'b0000, -1);
        run_instr("subs", 32'hE0500000, 4'b0110, -1);
        check("subs_flags", {28'h0, Flags}, 32'h6);
        run_instr("streq_t", 32'h05801000, 4'b0000, -1);
        run_instr("adds0", 32'hE0900000, 4'b0000, -1);
        check("adds_flags", {28'h0, Flags}, 32'h0);
        run_instr("streq_f", 32'h05801000, 4'b0000, -1);
        run_instr("b", 32'hEA000002, 4'b0000, -1);
        run_instr("add_pc", 32'hE08FF000, 4'b0000, -1);

        for (int k = 0; k < 400; k++)
            run_instr("rand", rand_instr(), 4'($urandom), -1);

        run_instr("subs2", 32'hE0500000, 4'b1011, -1);
        check("pre_abort_flags", {28'h0, Flags}, {28'h0, mflags});
        run_instr("ldr_abort", 32'hE5904004, 4'b0000, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
